// File: rtl/saddc_comparator_array_pkg.sv
// Shared types and helpers for the SADDC split-node comparator array.
// Optional statistics build macro used by the top: SADDC_CMP_STATS_EN.
package saddc_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_LE = 2'd0,
        CMP_LT = 2'd1,
        CMP_GE = 2'd2,
        CMP_EQ = 2'd3
    } cmp_mode_e;

    localparam int STAT_W = 32;

    // Widest operand the lane helper accepts; narrower lanes are sign-extended
    // into it, which preserves signed ordering and equality exactly.
    localparam int CMP_MAX_W = 64;

    function automatic logic cmp_lane(
        input logic signed [CMP_MAX_W-1:0] a,
        input logic signed [CMP_MAX_W-1:0] b,
        input cmp_mode_e                   mode
    );
        logic r;
        case (mode)
            CMP_LE:  r = (a <= b);
            CMP_LT:  r = (a < b);
            CMP_GE:  r = (a >= b);
            CMP_EQ:  r = (a == b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/saddc_comparator_array_if.sv
// Request/response bundle between the feature fetch unit (master) and the
// comparator array (slave).
interface saddc_comparator_array_if
    import saddc_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int TAG_W = 8
);
    localparam int CNT_W = $clog2(LANES + 1);

    logic                   io_req_valid;
    logic                   io_req_ready;
    logic [LANES*WIDTH-1:0] io_req_bits_feature;
    logic [LANES*WIDTH-1:0] io_req_bits_weights;
    cmp_mode_e              io_req_bits_mode;
    logic [TAG_W-1:0]       io_req_bits_tag;

    logic                   io_resp_valid;
    logic                   io_resp_ready;
    logic [LANES-1:0]       io_resp_bits_decision;
    logic [TAG_W-1:0]       io_resp_bits_tag;
    logic [CNT_W-1:0]       io_resp_bits_count;

    modport master (
        output io_req_valid, io_req_bits_feature, io_req_bits_weights,
               io_req_bits_mode, io_req_bits_tag, io_resp_ready,
        input  io_req_ready, io_resp_valid, io_resp_bits_decision,
               io_resp_bits_tag, io_resp_bits_count
    );

    modport slave (
        input  io_req_valid, io_req_bits_feature, io_req_bits_weights,
               io_req_bits_mode, io_req_bits_tag, io_resp_ready,
        output io_req_ready, io_resp_valid, io_resp_bits_decision,
               io_resp_bits_tag, io_resp_bits_count
    );

endinterface

// File: rtl/saddc_comparator_array_lane.sv
// One signed comparison with a mode mux. Purely combinational; WIDTH up to 64.
module saddc_cmp_lane
    import saddc_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_mode_e        mode,
    output logic             result
);
    logic signed [CMP_MAX_W-1:0] a_ext;
    logic signed [CMP_MAX_W-1:0] b_ext;

    assign a_ext  = CMP_MAX_W'($signed(a));
    assign b_ext  = CMP_MAX_W'($signed(b));
    assign result = cmp_lane(a_ext, b_ext, mode);

endmodule

// File: rtl/saddc_comparator_array.sv
// SADDC split-node comparator array: LANES signed compares per transaction
// over a 2-stage elastic pipeline (S1 operands, S2 decision/count/tag).
// Build option: define SADDC_CMP_STATS_EN to add request/true-count statistics.
module saddc_comparator_array
    import saddc_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    saddc_comparator_array_if.slave io
`ifdef SADDC_CMP_STATS_EN
    ,
    input  logic                 stat_clear,
    output logic [STAT_W-1:0]    stat_req,
    output logic [STAT_W-1:0]    stat_true
`endif
);
    localparam int CNT_W = $clog2(LANES + 1);

    logic                   s1_valid_reg;
    logic [LANES*WIDTH-1:0] s1_feature_reg;
    logic [LANES*WIDTH-1:0] s1_weights_reg;
    cmp_mode_e              s1_mode_reg;
    logic [TAG_W-1:0]       s1_tag_reg;

    logic                   s2_valid_reg;
    logic [LANES-1:0]       s2_decision_reg;
    logic [TAG_W-1:0]       s2_tag_reg;
    logic [CNT_W-1:0]       s2_count_reg;

    logic [LANES-1:0]       decision_next;
    logic [CNT_W-1:0]       count_next;
    logic                   s2_load;
    logic                   s1_move;
    logic                   req_fire;

    // S2 can take new data when empty or draining; S1 frees up when it can move.
    // Ready depends on resp_ready only, never on req_valid.
    assign s2_load         = !s2_valid_reg || io.io_resp_ready;
    assign s1_move         = s1_valid_reg && s2_load;
    assign io.io_req_ready = !s1_valid_reg || s1_move;
    assign req_fire        = io.io_req_valid && io.io_req_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            saddc_cmp_lane #(.WIDTH(WIDTH)) u_lane (
                .a      (s1_feature_reg[gi*WIDTH +: WIDTH]),
                .b      (s1_weights_reg[gi*WIDTH +: WIDTH]),
                .mode   (s1_mode_reg),
                .result (decision_next[gi])
            );
        end
    endgenerate

    // Popcount of the S1 decision vector, registered into S2 alongside it.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < LANES; i++) begin
            count_next = count_next + CNT_W'(decision_next[i]);
        end
    end

    // S1: capture operands on an accepted request; empties when it moves on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg   <= 1'b0;
            s1_feature_reg <= '0;
            s1_weights_reg <= '0;
            s1_mode_reg    <= CMP_LE;
            s1_tag_reg     <= '0;
        end else begin
            if (io.io_req_ready) begin
                s1_valid_reg <= io.io_req_valid;
            end
            if (req_fire) begin
                s1_feature_reg <= io.io_req_bits_feature;
                s1_weights_reg <= io.io_req_bits_weights;
                s1_mode_reg    <= io.io_req_bits_mode;
                s1_tag_reg     <= io.io_req_bits_tag;
            end
        end
    end

    // S2: register decision/count/tag; holds steady while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_reg    <= 1'b0;
            s2_decision_reg <= '0;
            s2_tag_reg      <= '0;
            s2_count_reg    <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_decision_reg <= decision_next;
                s2_tag_reg      <= s1_tag_reg;
                s2_count_reg    <= count_next;
            end
        end
    end

    assign io.io_resp_valid         = s2_valid_reg;
    assign io.io_resp_bits_decision = s2_decision_reg;
    assign io.io_resp_bits_tag      = s2_tag_reg;
    assign io.io_resp_bits_count    = s2_count_reg;

`ifdef SADDC_CMP_STATS_EN
    logic [STAT_W-1:0] stat_req_reg;
    logic [STAT_W-1:0] stat_true_reg;
    logic [STAT_W:0]   true_sum;
    logic              resp_fire;

    assign resp_fire = s2_valid_reg && io.io_resp_ready;
    assign true_sum  = {1'b0, stat_true_reg} + (STAT_W+1)'(s2_count_reg);

    // Accepted-request counter; clear beats a same-cycle increment, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_req_reg <= '0;
        end else if (stat_clear) begin
            stat_req_reg <= '0;
        end else if (req_fire && (stat_req_reg != {STAT_W{1'b1}})) begin
            stat_req_reg <= stat_req_reg + 1'b1;
        end
    end

    // Sum of counts over consumed responses; clear wins, saturates on carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_true_reg <= '0;
        end else if (stat_clear) begin
            stat_true_reg <= '0;
        end else if (resp_fire) begin
            stat_true_reg <= true_sum[STAT_W] ? {STAT_W{1'b1}} : true_sum[STAT_W-1:0];
        end
    end

    assign stat_req  = stat_req_reg;
    assign stat_true = stat_true_reg;
`endif

endmodule
